// File: rtl/i_axi_rd_bridge_pkg.sv
// Shared types and AXI constants for the instruction-side AXI read bridge.
package i_axi_rd_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/i_axi_rd_bridge.sv
// Turns instruction-cache miss requests into single-beat AXI4 reads, one outstanding at a time,
// dropping responses whose request was abandoned before the data came back.
module i_axi_rd_bridge
  import i_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned          A_WIDTH  = 32,
  parameter int unsigned          ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0]  AR_ID    = '0
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [A_WIDTH-1:0]  c_a,
  input  logic                c_strobe,
  output logic [31:0]         c_dout,
  output logic                c_ready,
  output logic                c_err,
  output logic [ID_WIDTH-1:0] arid,
  output logic [A_WIDTH-1:0]  araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]          dout_q, dout_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 match;

  // Single outstanding read: the ID and last flag carry no information.
  logic unused_r_sideband;
  assign unused_r_sideband = ^{rid, rlast};

  // The cache still wants this word only if it is strobing the same address.
  assign match = c_strobe && (c_a == addr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (c_strobe) begin
          addr_d  = c_a;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (arready) state_d = StData;
      end
      StData: begin
        if (rvalid) begin
          if (match) begin
            dout_d  = rdata;
            ready_d = 1'b1;
            err_d   = (rresp != RESP_OKAY);
            state_d = StResp;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign arvalid = (state_q == StAddr);
  assign rready  = (state_q == StData);
  assign araddr  = {addr_q[A_WIDTH-1:2], 2'b00};
  assign arid    = AR_ID;
  assign arlen   = LEN_SINGLE;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign c_dout  = dout_q;
  assign c_ready = ready_q;
  assign c_err   = err_q;

endmodule

// File: tb/tb_i_axi_rd_bridge.sv
// Self-checking bench for i_axi_rd_bridge: directed scenarios plus a randomized cache/slave run.
module tb_i_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] c_a;
  logic        c_strobe;
  logic [31:0] c_dout;
  logic        c_ready;
  logic        c_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  i_axi_rd_bridge dut (
    .clk      (clk),
    .clrn     (clrn),
    .c_a      (c_a),
    .c_strobe (c_strobe),
    .c_dout   (c_dout),
    .c_ready  (c_ready),
    .c_err    (c_err),
    .arid     (arid),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .arvalid  (arvalid),
    .arready  (arready),
    .rid      (rid),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int crdy_count = 0;

  // Reference model: what the bridge is doing at the transaction level.
  logic        m_arv, m_rr, m_crdy, m_cerr;
  logic [31:0] m_dout, m_req;
  logic        ar_hs, r_hs;
  logic        pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_arv = 0; m_rr = 0; m_crdy = 0; m_cerr = 0; m_dout = 0; m_req = 0;
    ar_hs = 0; r_hs = 0;
  endtask

  // Advance the model across one rising edge using the inputs presented in that cycle.
  task automatic model_step();
    ar_hs = m_arv && arready;
    r_hs  = m_rr && rvalid;
    if (m_crdy) begin
      m_crdy = 0;
      m_cerr = 0;
    end else if (m_arv) begin
      if (arready) begin m_arv = 0; m_rr = 1; end
    end else if (m_rr) begin
      if (rvalid) begin
        m_rr = 0;
        if (c_strobe && c_a == m_req) begin
          m_dout = rdata;
          m_crdy = 1;
          m_cerr = (rresp != 2'b00);
        end
      end
    end else if (c_strobe) begin
      m_req = c_a;
      m_arv = 1;
    end
  endtask

  task automatic compare_all();
    chk("arvalid", {31'd0, arvalid}, {31'd0, m_arv});
    if (m_arv) chk("araddr", araddr, {m_req[31:2], 2'b00});
    chk("rready", {31'd0, rready}, {31'd0, m_rr});
    chk("c_ready", {31'd0, c_ready}, {31'd0, m_crdy});
    chk("c_err", {31'd0, c_err}, {31'd0, m_cerr});
    chk("c_dout", c_dout, m_dout);
    if (c_ready) crdy_count++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    c_strobe = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
  endtask

  task automatic do_reset();
    clrn = 0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    clrn = 1;
  endtask

  int base;

  initial begin
    c_a = 0; rid = 0; rlast = 1; pend = 0;
    do_reset();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_c_ready", {31'd0, c_ready}, 32'd0);
    chk("rst_c_dout", c_dout, 32'd0);
    chk("arlen", {24'd0, arlen}, 32'd0);
    chk("arsize", {29'd0, arsize}, 32'd2);
    chk("arburst", {30'd0, arburst}, 32'd1);
    chk("arid", {28'd0, arid}, 32'd0);

    // 1: immediate slave, c_ready in cycle 3
    c_a = 32'h1FC0_0004; c_strobe = 1; arready = 1; rvalid = 1; rdata = 32'h2408_0001;
    step();
    chk("t1_arvalid_c1", {31'd0, arvalid}, 32'd1);
    chk("t1_araddr", araddr, 32'h1FC0_0004);
    step();
    chk("t1_c_ready_c2", {31'd0, c_ready}, 32'd0);
    step();
    chk("t1_c_ready_c3", {31'd0, c_ready}, 32'd1);
    chk("t1_c_dout", c_dout, 32'h2408_0001);
    chk("t1_c_err", {31'd0, c_err}, 32'd0);
    idle_inputs();
    step(); step();

    // 2: slow AR and R, address held, one pulse
    base = crdy_count;
    c_a = 32'h1FC0_0010; c_strobe = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_araddr_stable", araddr, 32'h1FC0_0010);
    end
    arready = 1;
    step();
    arready = 0;
    step(); step();
    rvalid = 1; rdata = 32'hCAFE_0002;
    step();
    chk("t2_c_dout", c_dout, 32'hCAFE_0002);
    idle_inputs();
    step(); step(); step();
    chk("t2_pulses", crdy_count - base, 1);

    // 3: address changes while waiting for data
    base = crdy_count;
    c_a = 32'h100; c_strobe = 1; arready = 1;
    step(); step();
    arready = 0; c_a = 32'h200; rvalid = 1; rdata = 32'hDEAD_0001;
    step();
    chk("t3_no_ready", {31'd0, c_ready}, 32'd0);
    rvalid = 0;
    step();
    chk("t3_second_araddr", araddr, 32'h200);
    chk("t3_second_arvalid", {31'd0, arvalid}, 32'd1);
    arready = 1;
    step();
    arready = 0; rvalid = 1; rdata = 32'h1234_5678;
    step();
    chk("t3_c_dout", c_dout, 32'h1234_5678);
    idle_inputs();
    step(); step();
    chk("t3_pulses", crdy_count - base, 1);

    // 4: strobe drops while AR pending
    base = crdy_count;
    c_a = 32'h300; c_strobe = 1;
    step();
    c_strobe = 0;
    step(); step();
    chk("t4_arvalid_held", {31'd0, arvalid}, 32'd1);
    arready = 1;
    step();
    arready = 0; rvalid = 1; rdata = 32'h5555_AAAA;
    step();
    rvalid = 0;
    step();
    chk("t4_arvalid_idle", {31'd0, arvalid}, 32'd0);
    chk("t4_no_pulse", crdy_count - base, 0);
    chk("t4_dout_kept", c_dout, 32'h1234_5678);

    // 5: error response
    c_a = 32'h400; c_strobe = 1; arready = 1; rvalid = 1; rresp = 2'b10; rdata = 32'hBAD0_BAD0;
    step(); step(); step();
    chk("t5_c_ready", {31'd0, c_ready}, 32'd1);
    chk("t5_c_err", {31'd0, c_err}, 32'd1);
    idle_inputs();
    step();
    chk("t5_c_err_clear", {31'd0, c_err}, 32'd0);

    // 6: asynchronous reset while in the data phase
    base = crdy_count;
    c_a = 32'h500; c_strobe = 1; arready = 1;
    step(); step();
    chk("t6_in_data", {31'd0, rready}, 32'd1);
    arready = 0;
    #3 clrn = 0;
    #1;
    chk("t6_rready", {31'd0, rready}, 32'd0);
    chk("t6_arvalid", {31'd0, arvalid}, 32'd0);
    chk("t6_c_dout", c_dout, 32'd0);
    chk("t6_c_err", {31'd0, c_err}, 32'd0);
    model_reset();
    c_strobe = 0;
    @(posedge clk);
    #1 clrn = 1;
    rvalid = 1; rdata = 32'h7777_7777;
    step(); step();
    rvalid = 0;
    step();
    chk("t6_no_pulse", crdy_count - base, 0);

    // Randomized cache and slave behaviour
    do_reset();
    base = crdy_count;
    pend = 0;
    for (int n = 0; n < 4000; n++) begin
      arready = ($urandom % 3) != 0;
      if (pend && !rvalid && ($urandom % 2 == 0)) begin
        rvalid = 1;
        rdata  = $urandom;
        rresp  = ($urandom % 4 == 0) ? 2'($urandom % 4) : 2'b00;
      end
      if (m_crdy) begin
        if ($urandom % 2 == 0) c_strobe = 0;
        else c_a = $urandom & 32'hFFFF_FFFC;
      end else if (c_strobe) begin
        if ($urandom % 16 == 0) c_strobe = 0;
        if ($urandom % 12 == 0) c_a = ($urandom % 2) ? 32'h100 : $urandom;
      end else if ($urandom % 3 == 0) begin
        c_strobe = 1;
        c_a = ($urandom % 2) ? 32'h1FC0_0000 + 32'(($urandom % 8) * 4) : $urandom;
      end
      step();
      if (ar_hs) pend = 1;
      if (r_hs) begin pend = 0; rvalid = 0; end
    end
    chk("rand_some_deliveries", {31'd0, (crdy_count - base) > 20}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
